// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-select and FSM state definitions for the control unit.
// CU_SINGLE_STEP_EN adds the STEP_WAIT state encoding.
package cu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Encodings are visible on CurState, so they are pinned explicitly.
  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    SUB    = 4'd8,
    HALT   = 4'd9
`ifdef CU_SINGLE_STEP_EN
    , STEP_WAIT = 4'd10
`endif
  } state_t;

  // Unassigned opcodes fall through to NOOP.
  function automatic state_t op_to_state(input logic [3:0] op);
    case (op)
      OP_STORE: return STORE;
      OP_LOAD:  return LOAD_A;
      OP_ADD:   return ADD;
      OP_SUB:   return SUB;
      OP_HALT:  return HALT;
      default:  return NOOP;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit, the instruction ROM and the datapath.
// master = control unit side, slave = ROM/datapath side.
interface control_unit_if #(parameter int PC_W = 7);
  logic [15:0]     imData;
  logic [PC_W-1:0] imAddr;
  logic            imRdEn;
  logic            dmWriteEn;
  logic [7:0]      dmAddr;
  logic            MuxS;
  logic [3:0]      regAaddr;
  logic [3:0]      regBaddr;
  logic [3:0]      regWaddr;
  logic            regWriteEn;
  logic [2:0]      aluSel;
  logic [PC_W-1:0] PC;
  logic [3:0]      CurState;
  logic            Halted;

  modport master (
    input  imData,
    output imAddr, imRdEn, dmWriteEn, dmAddr, MuxS, regAaddr, regBaddr,
           regWaddr, regWriteEn, aluSel, PC, CurState, Halted
  );

  modport slave (
    output imData,
    input  imAddr, imRdEn, dmWriteEn, dmAddr, MuxS, regAaddr, regBaddr,
           regWaddr, regWriteEn, aluSel, PC, CurState, Halted
  );
endinterface

// File: rtl/control_unit_pc_counter.sv
// Program counter: synchronous clear and increment enable, wraps silently.
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i)      pc_d = '0;
    else if (inc_i) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Moore sequencing FSM for the six-instruction processor: fetch, decode, execute.
// Optional single-step mode: define CU_SINGLE_STEP_EN (adds Step port and STEP_WAIT).
//
// state     | meaning
// INIT      | clear PC, go fetch
// FETCH     | ROM read of address PC
// DECODE    | latch IR, PC+1, branch on opcode from ROM data
// NOOP      | no operation
// LOAD_A    | present memory address, wait for RAM latency
// LOAD_B    | write memory data into RF[Rd]
// STORE     | write RF[Ra] to memory
// ADD / SUB | RF[Rd] <= RF[Ra] +/- RF[Rb]
// HALT      | stop until reset
// STEP_WAIT | idle until Step (single-step build only)
module control_unit
  import cu_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic Clock,
  input  logic ResetN,
`ifdef CU_SINGLE_STEP_EN
  input  logic Step,
`endif
  control_unit_if.master bus
);

`ifdef CU_SINGLE_STEP_EN
  localparam state_t EXEC_NEXT = STEP_WAIT;
`else
  localparam state_t EXEC_NEXT = FETCH;
`endif

  state_t          state_q, state_d;
  logic [11:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc;

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk_i  (Clock),
    .rst_ni (ResetN),
    .clr_i  (state_q == INIT),
    .inc_i  (state_q == DECODE),
    .pc_o   (pc)
  );

  // The opcode steers the branch straight from ROM data, so only operands are kept.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      INIT:   state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        ir_d    = bus.imData[11:0];
        state_d = op_to_state(bus.imData[15:12]);
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B, STORE, ADD, SUB, NOOP: state_d = EXEC_NEXT;
      HALT:   state_d = HALT;
`ifdef CU_SINGLE_STEP_EN
      STEP_WAIT: if (Step) state_d = FETCH;
`endif
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  logic       rd_en, dm_we, rf_we, mux_s, halted;
  logic [7:0] dm_addr;
  logic [3:0] ra, rb, rw;
  logic [2:0] alu;

  always_comb begin
    rd_en   = 1'b0;
    dm_we   = 1'b0;
    rf_we   = 1'b0;
    mux_s   = 1'b0;
    halted  = 1'b0;
    dm_addr = '0;
    ra      = '0;
    rb      = '0;
    rw      = '0;
    alu     = ALU_PASS;
    case (state_q)
      FETCH:  rd_en = 1'b1;
      LOAD_A: begin
        dm_addr = ir_q[11:4];
        mux_s   = 1'b1;
      end
      LOAD_B: begin
        dm_addr = ir_q[11:4];
        mux_s   = 1'b1;
        rw      = ir_q[3:0];
        rf_we   = 1'b1;
      end
      STORE: begin
        dm_addr = ir_q[11:4];
        ra      = ir_q[3:0];
        dm_we   = 1'b1;
      end
      ADD, SUB: begin
        ra    = ir_q[11:8];
        rb    = ir_q[7:4];
        rw    = ir_q[3:0];
        alu   = (state_q == ADD) ? ALU_ADD : ALU_SUB;
        rf_we = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // Strobes are masked while reset is low so nothing is written in the reset cycle.
  assign bus.imRdEn     = rd_en & ResetN;
  assign bus.dmWriteEn  = dm_we & ResetN;
  assign bus.regWriteEn = rf_we & ResetN;
  assign bus.imAddr     = pc;
  assign bus.PC         = pc;
  assign bus.dmAddr     = dm_addr;
  assign bus.MuxS       = mux_s;
  assign bus.regAaddr   = ra;
  assign bus.regBaddr   = rb;
  assign bus.regWaddr   = rw;
  assign bus.aluSel     = alu;
  assign bus.CurState   = state_q;
  assign bus.Halted     = halted;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, corner-case
// sequences, and random programs checked against an instruction-level model.
module tb_control_unit;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic Step = 1'b1;
  localparam int SW = 1;
`else
  localparam int SW = 0;
`endif

  control_unit_if #(.PC_W(7)) bus ();

  control_unit #(.PC_W(7)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
`ifdef CU_SINGLE_STEP_EN
    .Step   (Step),
`endif
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Synchronous instruction ROM: data appears one cycle after the read.
  logic [15:0] rom [128];
  always @(posedge Clock) if (bus.imRdEn) bus.imData <= rom[bus.imAddr];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] cs;
    logic [6:0] pc;
    logic       rd, dmwe, rwe, mux, hlt;
    logic [7:0] dm;
    logic [3:0] ra, rb, rw;
    logic [2:0] alu;
    logic       c_dm, c_ra, c_rb, c_rw, c_mux;
  } exp_t;

  exp_t eq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] cs, input logic [6:0] pc);
    exp_t e;
    e    = '0;
    e.cs = cs;
    e.pc = pc;
    return e;
  endfunction

  task automatic check_cycle(input string nm, input exp_t e);
    logic ok;
    ok = (bus.CurState === e.cs) && (bus.PC === e.pc) && (bus.imAddr === e.pc) &&
         (bus.imRdEn === e.rd) && (bus.dmWriteEn === e.dmwe) &&
         (bus.regWriteEn === e.rwe) && (bus.Halted === e.hlt) && (bus.aluSel === e.alu);
    if (e.c_dm  && bus.dmAddr   !== e.dm)  ok = 1'b0;
    if (e.c_ra  && bus.regAaddr !== e.ra)  ok = 1'b0;
    if (e.c_rb  && bus.regBaddr !== e.rb)  ok = 1'b0;
    if (e.c_rw  && bus.regWaddr !== e.rw)  ok = 1'b0;
    if (e.c_mux && bus.MuxS     !== e.mux) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got st=%0d pc=%0d rd=%b dmwe=%b rwe=%b hlt=%b alu=%0d dm=%h ra=%h rb=%h rw=%h mux=%b expected st=%0d pc=%0d rd=%b dmwe=%b rwe=%b hlt=%b alu=%0d dm=%h ra=%h rb=%h rw=%h mux=%b",
               nm, bus.CurState, bus.PC, bus.imRdEn, bus.dmWriteEn, bus.regWriteEn, bus.Halted,
               bus.aluSel, bus.dmAddr, bus.regAaddr, bus.regBaddr, bus.regWaddr, bus.MuxS,
               e.cs, e.pc, e.rd, e.dmwe, e.rwe, e.hlt, e.alu, e.dm, e.ra, e.rb, e.rw, e.mux);
    end
  endtask

  // Instruction-level model: appends the cycle-by-cycle view of one instruction.
  function automatic void push_instr(input logic [6:0] pc, input logic [15:0] ins);
    exp_t       e;
    logic [6:0] npc;
    npc  = pc + 7'd1;
    e    = blank(4'd1, pc);
    e.rd = 1'b1;
    eq.push_back(e);
    eq.push_back(blank(4'd2, pc));
    case (ins[15:12])
      4'h1: begin
        e = blank(4'd6, npc);
        e.dmwe = 1'b1; e.dm = ins[11:4]; e.c_dm = 1'b1; e.ra = ins[3:0]; e.c_ra = 1'b1;
        eq.push_back(e);
      end
      4'h2: begin
        e = blank(4'd4, npc);
        e.dm = ins[11:4]; e.c_dm = 1'b1; e.mux = 1'b1; e.c_mux = 1'b1;
        eq.push_back(e);
        e.cs = 4'd5; e.rw = ins[3:0]; e.c_rw = 1'b1; e.rwe = 1'b1;
        eq.push_back(e);
      end
      4'h3, 4'h4: begin
        e = blank((ins[15:12] == 4'h3) ? 4'd7 : 4'd8, npc);
        e.alu = (ins[15:12] == 4'h3) ? 3'd1 : 3'd2;
        e.ra = ins[11:8]; e.rb = ins[7:4]; e.rw = ins[3:0];
        e.c_ra = 1'b1; e.c_rb = 1'b1; e.c_rw = 1'b1; e.c_mux = 1'b1; e.rwe = 1'b1;
        eq.push_back(e);
      end
      4'h5: begin
        e = blank(4'd9, npc);
        e.hlt = 1'b1;
        eq.push_back(e);
      end
      default: eq.push_back(blank(4'd3, npc));
    endcase
    if (SW != 0 && ins[15:12] != 4'h5) eq.push_back(blank(4'd10, npc));
  endfunction

  // Called at a falling edge; returns at the falling edge of the first FETCH.
  task automatic do_reset();
    exp_t e;
    ResetN = 1'b0;
    #1;
    chk("rst_force_rden", bus.imRdEn, 0);
    chk("rst_force_dmwe", bus.dmWriteEn, 0);
    chk("rst_force_rwe", bus.regWriteEn, 0);
    @(negedge Clock);
    @(negedge Clock);
    e = blank(4'd0, 7'd0);
    e.c_dm = 1'b1; e.c_ra = 1'b1; e.c_rb = 1'b1; e.c_rw = 1'b1; e.c_mux = 1'b1;
    check_cycle("reset_state", e);
    ResetN = 1'b1;
    @(negedge Clock);
    e    = blank(4'd1, 7'd0);
    e.rd = 1'b1;
    check_cycle("first_fetch", e);
  endtask

  typedef struct {
    logic [15:0] ins;
    int          cpi;
    logic [3:0]  st1, st2;
    logic [7:0]  dm;
    logic [3:0]  ra, rb, rw;
    logic [2:0]  alu;
    int          n_dmwe, n_rwe;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int   guard, bad, cyc, ndw, nrw;
    exp_t e;
    logic [6:0] pc;

    tbl[0] = '{16'h2053, 4, 4'd4, 4'd5, 8'h05, 4'h0, 4'h0, 4'h3, 3'd0, 0, 1};
    tbl[1] = '{16'h3123, 3, 4'd7, 4'd0, 8'h00, 4'h1, 4'h2, 4'h3, 3'd1, 0, 1};
    tbl[2] = '{16'h4314, 3, 4'd8, 4'd0, 8'h00, 4'h3, 4'h1, 4'h4, 3'd2, 0, 1};
    tbl[3] = '{16'h10A6, 3, 4'd6, 4'd0, 8'h0A, 4'h6, 4'h0, 4'h0, 3'd0, 1, 0};
    tbl[4] = '{16'hF000, 3, 4'd3, 4'd0, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 0, 0};
    tbl[5] = '{16'h0000, 3, 4'd3, 4'd0, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 0, 0};
    tbl[6] = '{16'h6ABC, 3, 4'd3, 4'd0, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 0, 0};

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 7; i++) rom[i] = tbl[i].ins;

    @(negedge Clock);
    do_reset();

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      chk("fetch_state", bus.CurState, 1);
      chk("fetch_addr", bus.imAddr, i);
      chk("fetch_rden", bus.imRdEn, 1);
      @(negedge Clock);
      chk("decode_state", bus.CurState, 2);
      @(negedge Clock);
      chk("exec_state", bus.CurState, tbl[i].st1);
      chk("pc_inc", bus.PC, i + 1);
      chk("alu_sel", bus.aluSel, tbl[i].alu);
      if (tbl[i].st1 == 4'd4 || tbl[i].st1 == 4'd6) chk("dm_addr", bus.dmAddr, tbl[i].dm);
      if (tbl[i].st1 == 4'd4) chk("load_a_mux", bus.MuxS, 1);
      if (tbl[i].st1 == 4'd6) chk("store_ra", bus.regAaddr, tbl[i].ra);
      if (tbl[i].st1 == 4'd7 || tbl[i].st1 == 4'd8) begin
        chk("alu_ra", bus.regAaddr, tbl[i].ra);
        chk("alu_rb", bus.regBaddr, tbl[i].rb);
        chk("alu_rw", bus.regWaddr, tbl[i].rw);
        chk("alu_mux", bus.MuxS, 0);
      end
      cyc = 2; ndw = 0; nrw = 0;
      while (bus.CurState !== 4'd1 && cyc < 12) begin
        if (cyc == 3 && tbl[i].cpi == 4) begin
          chk("exec2_state", bus.CurState, tbl[i].st2);
          chk("load_b_dm", bus.dmAddr, tbl[i].dm);
          chk("load_b_mux", bus.MuxS, 1);
          chk("load_b_rw", bus.regWaddr, tbl[i].rw);
        end
        ndw += int'(bus.dmWriteEn);
        nrw += int'(bus.regWriteEn);
        @(negedge Clock);
        cyc++;
      end
      chk("cpi", cyc, tbl[i].cpi + SW);
      chk("dmwe_pulses", ndw, tbl[i].n_dmwe);
      chk("rwe_pulses", nrw, tbl[i].n_rwe);
    end

    // Reset landing in LOAD_A aborts the load
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2053;
    do_reset();
    @(negedge Clock);
    @(negedge Clock);
    chk("midload_in_a", bus.CurState, 4);
    ResetN = 1'b0;
    #1;
    chk("midload_a_rwe", bus.regWriteEn, 0);
    @(negedge Clock);
    chk("midload_a_init", bus.CurState, 0);
    chk("midload_a_norwe", bus.regWriteEn, 0);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    chk("midload_refetch", bus.CurState, 1);

    // Reset in LOAD_B masks the register write combinationally
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    chk("midload_in_b", bus.CurState, 5);
    chk("midload_b_rwe_on", bus.regWriteEn, 1);
    ResetN = 1'b0;
    #1;
    chk("midload_b_rwe_masked", bus.regWriteEn, 0);
    @(negedge Clock);
    chk("midload_b_init", bus.CurState, 0);
    ResetN = 1'b1;
    @(negedge Clock);

    // PC wrap and HALT
    rom[0] = 16'h0000;
    do_reset();
    @(negedge Clock);
    @(negedge Clock);
    rom[0] = 16'h5000;
    guard = 0;
    while (!(bus.CurState === 4'd1 && bus.imAddr === 7'd127) && guard < 1000) begin
      @(negedge Clock);
      guard++;
    end
    chk("wrap_reached_127", int'(guard < 1000), 1);
    @(negedge Clock);
    @(negedge Clock);
    chk("wrap_pc_zero", bus.PC, 0);
    while (bus.CurState !== 4'd1 && guard < 1010) begin
      @(negedge Clock);
      guard++;
    end
    chk("wrap_fetch_addr0", bus.imAddr, 0);
    @(negedge Clock);
    @(negedge Clock);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.CurState !== 4'd9 || bus.Halted !== 1'b1 || bus.imRdEn !== 1'b0 ||
          bus.dmWriteEn !== 1'b0 || bus.regWriteEn !== 1'b0 || bus.PC !== 7'd1) bad++;
      @(negedge Clock);
    end
    chk("halt_hold_50", bad, 0);
    ResetN = 1'b0;
    @(negedge Clock);
    chk("halt_reset_init", bus.CurState, 0);
    chk("halt_reset_flag", bus.Halted, 0);
    ResetN = 1'b1;
    @(negedge Clock);

`ifdef CU_SINGLE_STEP_EN
    // Single step: STEP_WAIT holds until Step
    rom[0] = 16'h0000;
    Step = 1'b0;
    do_reset();
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.CurState !== 4'd10 || bus.imRdEn !== 1'b0 || bus.regWriteEn !== 1'b0 ||
          bus.dmWriteEn !== 1'b0) bad++;
      @(negedge Clock);
    end
    chk("step_wait_hold", bad, 0);
    Step = 1'b1;
    @(negedge Clock);
    chk("step_release_fetch", bus.CurState, 1);
    chk("step_release_addr", bus.imAddr, 1);
    @(negedge Clock);
`endif

    // Random programs against the instruction-level model
    for (int i = 0; i < 128; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'h5) w[15:12] = 4'h0;
      rom[i] = w;
    end
    do_reset();
    pc = 7'd0;
    for (int n = 0; n < 300; n++) begin
      eq.delete();
      push_instr(pc, rom[pc]);
      while (eq.size() > 0) begin
        e = eq.pop_front();
        check_cycle($sformatf("rand_i%0d_op%0h", n, rom[pc][15:12]), e);
        @(negedge Clock);
      end
      pc = pc + 7'd1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
